// File: rtl/pdp_ram_fifo.sv
// Single-clock FIFO on an inferred pseudo-dual-port RAM with count and registered flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow error outputs.
module pdp_ram_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 9,
  parameter int AFULL_THRESH  = 480,
  parameter int AEMPTY_THRESH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc, rd_acc;

  // Acceptance judged on the registered flags, so full/empty never see a same-cycle update.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid     <= rd_acc;
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AFULL_THRESH));
      almost_empty <= (count_nxt <= CW'(AEMPTY_THRESH));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_en && full)  ovf_err <= 1'b1;
      if (rd_en && empty) udf_err <= 1'b1;
    end
  end
`endif

endmodule
